// File: rtl/imem_pkg.sv
// Shared instruction-memory constants and the boot loader state encoding.
// The instruction memory and the loader both import these.
package imem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        ERR
    } loader_state_t;

    localparam logic [31:0] IMEM_BASE_ADDR   = 32'h8000_0000;
    localparam logic [31:0] IMEM_WORD_OFFSET = 32'h2000_0000;
    localparam int          IMEM_DEPTH       = 255;
    localparam logic [7:0]  LOADER_SYNC      = 8'hA5;

endpackage

// File: rtl/imem_loader_byte_to_word_asm.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
// word is valid combinationally in the cycle the 4th byte is presented.
module byte_to_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  idx_reg;
    logic [31:0] shift_reg;

    // The incoming byte is merged into its lane so the full word is ready
    // on the same cycle as the final byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign word[8*gi +: 8] = (idx_reg == 2'(gi)) ? in_byte : shift_reg[8*gi +: 8];
        end
    endgenerate

    assign word_valid = in_valid && (idx_reg == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg   <= 2'd0;
            shift_reg <= 32'd0;
        end else if (clr) begin
            idx_reg   <= 2'd0;
        end else if (in_valid) begin
            idx_reg   <= idx_reg + 2'd1;
            shift_reg <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses framed byte stream, writes 32-bit words into the
// instruction memory and holds the core while a program is being loaded.
import imem_pkg::*;

module imem_loader #(
    parameter int          width     = 32,
    parameter int          depth     = IMEM_DEPTH,
    parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR,
    parameter logic [7:0]  SYNC_BYTE = LOADER_SYNC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             wr_en,
    output logic [width-1:0] wr_addr,
    output logic [width-1:0] wr_data,
    output logic             cpu_hold,
    output logic             load_done,
    output logic             load_err,
    output logic [7:0]       words_loaded
);

    loader_state_t    state_reg, state_next;
    logic [7:0]       len_lo_reg, len_lo_next;
    logic [15:0]      len_reg, len_next;
    logic [7:0]       checksum_reg, checksum_next;
    logic [7:0]       words_reg, words_next;
    logic             wr_en_reg, wr_en_next;
    logic [width-1:0] wr_addr_reg, wr_addr_next;
    logic [width-1:0] wr_data_reg, wr_data_next;
    logic             cpu_hold_reg, cpu_hold_next;
    logic             load_done_reg, load_done_next;
    logic             load_err_reg, load_err_next;

    logic        accept;
    logic        is_sync;
    logic [15:0] frame_len;
    logic [31:0] asm_word;
    logic        asm_word_valid;

    // Stalling input during the write cycle keeps at most one word in flight.
    assign rx_ready  = (state_reg != ERR) && !wr_en_reg;
    assign accept    = rx_valid && rx_ready;
    assign is_sync   = accept && (state_reg == IDLE) && (rx_data == SYNC_BYTE);
    assign frame_len = {rx_data, len_lo_reg};

    byte_to_word_asm u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (is_sync),
        .in_valid   (accept && (state_reg == DATA)),
        .in_byte    (rx_data),
        .word       (asm_word),
        .word_valid (asm_word_valid)
    );

    always_comb begin
        state_next     = state_reg;
        len_lo_next    = len_lo_reg;
        len_next       = len_reg;
        checksum_next  = checksum_reg;
        words_next     = words_reg;
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        cpu_hold_next  = cpu_hold_reg;
        load_done_next = 1'b0;
        load_err_next  = load_err_reg;

        case (state_reg)
            IDLE: begin
                if (is_sync) begin
                    state_next    = LEN_LO;
                    load_err_next = 1'b0;
                    words_next    = 8'd0;
                    checksum_next = 8'd0;
                    cpu_hold_next = 1'b1;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_lo_next = rx_data;
                    state_next  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_next = frame_len;
                    if (frame_len == 16'd0 || frame_len > 16'(depth)) begin
                        state_next    = ERR;
                        load_err_next = 1'b1;
                        cpu_hold_next = 1'b0;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    checksum_next = checksum_reg ^ rx_data;
                    if (asm_word_valid) begin
                        wr_en_next   = 1'b1;
                        wr_data_next = width'(asm_word);
                        wr_addr_next = BASE_ADDR + width'({words_reg, 2'b00});
                        words_next   = words_reg + 8'd1;
                        if ({8'd0, words_reg} + 16'd1 == len_reg)
                            state_next = CSUM;
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    cpu_hold_next = 1'b0;
                    if (rx_data == checksum_reg) begin
                        load_done_next = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        load_err_next = 1'b1;
                        state_next    = ERR;
                    end
                end
            end
            ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            len_lo_reg    <= 8'd0;
            len_reg       <= 16'd0;
            checksum_reg  <= 8'd0;
            words_reg     <= 8'd0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= width'(BASE_ADDR);
            wr_data_reg   <= '0;
            cpu_hold_reg  <= 1'b0;
            load_done_reg <= 1'b0;
            load_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_lo_reg    <= len_lo_next;
            len_reg       <= len_next;
            checksum_reg  <= checksum_next;
            words_reg     <= words_next;
            wr_en_reg     <= wr_en_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            cpu_hold_reg  <= cpu_hold_next;
            load_done_reg <= load_done_next;
            load_err_reg  <= load_err_next;
        end
    end

    assign wr_en        = wr_en_reg;
    assign wr_addr      = wr_addr_reg;
    assign wr_data      = wr_data_reg;
    assign cpu_hold     = cpu_hold_reg;
    assign load_done    = load_done_reg;
    assign load_err     = load_err_reg;
    assign words_loaded = words_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a frame-level reference model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [7:0]  words_loaded;

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int max_gap = 0;
    int done_cnt = 0;
    logic err_prev = 1'b0;

    logic [7:0]  frame_q[$];
    logic [31:0] w_q[$];
    logic [63:0] exp_wr_q[$];
    logic [63:0] obs_wr_q[$];
    int          obs_cyc_q[$];
    int          acc_cyc[int];
    int          sync_idx;
    int          exp_done;
    int          exp_err;
    int          exp_words;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                obs_wr_q.push_back({wr_addr, wr_data});
                obs_cyc_q.push_back(cyc);
                check("rx_ready_in_write", 32'(rx_ready), 32'd0);
            end
            if (load_done) begin
                done_cnt++;
                check("hold_at_done", 32'(cpu_hold), 32'd0);
            end
            if (load_err && !err_prev)
                check("hold_at_err", 32'(cpu_hold), 32'd0);
            err_prev = load_err;
        end
    end

    // Frame builders: w_q holds the words, csum_delta corrupts the checksum.
    task automatic build_frame(input logic [7:0] csum_delta);
        logic [7:0] cs = 8'd0;
        int n = w_q.size();
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        foreach (w_q[k]) begin
            for (int j = 0; j < 4; j++) begin
                frame_q.push_back(8'(w_q[k] >> (8 * j)));
                cs ^= 8'(w_q[k] >> (8 * j));
            end
        end
        frame_q.push_back(cs ^ csum_delta);
    endtask

    task automatic build_len_only(input int n);
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
    endtask

    // Reference: parse the byte stream by the frame rules.
    task automatic model_frame();
        int i = 0;
        int n;
        logic [7:0]  cs = 8'd0;
        logic [31:0] w;
        exp_wr_q.delete();
        exp_done = 0;
        exp_err = 0;
        exp_words = 0;
        while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
        sync_idx = i;
        i++;
        n = int'(frame_q[i]) + 256 * int'(frame_q[i+1]);
        i += 2;
        if (n == 0 || n > 255) begin
            exp_err = 1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            w = 32'd0;
            for (int j = 0; j < 4; j++) begin
                w |= 32'(frame_q[i]) << (8 * j);
                cs ^= frame_q[i];
                i++;
            end
            exp_wr_q.push_back({32'h8000_0000 + 32'(4 * k), w});
        end
        exp_words = n;
        if (frame_q[i] == cs) exp_done = 1;
        else exp_err = 1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int idx);
        int gap = $urandom_range(0, max_gap);
        int budget = 0;
        repeat (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!rx_ready) begin
            check("rx_ready_timeout", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
            return;
        end
        acc_cyc[idx] = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic run_frame();
        int nw;
        model_frame();
        obs_wr_q.delete();
        obs_cyc_q.delete();
        acc_cyc.delete();
        done_cnt = 0;
        foreach (frame_q[b]) begin
            send_byte(frame_q[b], b);
            if (b == sync_idx) begin
                check("hold_after_sync", 32'(cpu_hold), 32'd1);
                check("err_cleared_at_sync", 32'(load_err), 32'd0);
            end
        end
        repeat (4) @(negedge clk);
        check("write_count", 32'(obs_wr_q.size()), 32'(exp_wr_q.size()));
        nw = (obs_wr_q.size() < exp_wr_q.size()) ? obs_wr_q.size() : exp_wr_q.size();
        for (int k = 0; k < nw; k++) begin
            check("wr_addr", obs_wr_q[k][63:32], exp_wr_q[k][63:32]);
            check("wr_data", obs_wr_q[k][31:0], exp_wr_q[k][31:0]);
            check("wr_latency", 32'(obs_cyc_q[k]), 32'(acc_cyc[sync_idx + 6 + 4 * k] + 1));
        end
        check("done_count", 32'(done_cnt), 32'(exp_done));
        check("load_err", 32'(load_err), 32'(exp_err));
        check("words_loaded", 32'(words_loaded), 32'(exp_words));
        check("hold_end", 32'(cpu_hold), 32'd0);
        $display("frame bytes=%0d writes=%0d done=%0d err=%0d", frame_q.size(),
                 obs_wr_q.size(), done_cnt, load_err);
    endtask

    task automatic check_reset_outputs();
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", wr_addr, 32'h8000_0000);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // single NOP, back-to-back
        max_gap = 0;
        w_q = '{32'h0000_0013};
        build_frame(8'h00);
        run_frame();

        // two words with random gaps
        max_gap = 3;
        w_q = '{32'h0050_0093, 32'h0010_8113};
        build_frame(8'h00);
        run_frame();

        // illegal lengths, each followed by a good frame
        build_len_only(0);
        run_frame();
        w_q = '{32'hDEAD_BEEF};
        build_frame(8'h00);
        run_frame();
        build_len_only(256);
        run_frame();
        w_q = '{32'h1234_5678, 32'h9ABC_DEF0};
        build_frame(8'h00);
        run_frame();

        // checksum off by one
        w_q = '{32'h0000_0013, 32'h0050_0093, 32'h0010_8113};
        build_frame(8'h01);
        run_frame();

        // garbage before sync, and sync values as data
        w_q = '{32'hA5A5_00A5};
        build_frame(8'h00);
        frame_q.push_front(8'h13);
        frame_q.push_front(8'hFF);
        frame_q.push_front(8'h00);
        run_frame();

        // random frames
        for (int f = 0; f < 6; f++) begin
            w_q.delete();
            for (int k = 0; k < $urandom_range(1, 6); k++) w_q.push_back($urandom);
            build_frame(($urandom_range(0, 3) == 0) ? 8'(($urandom_range(1, 255))) : 8'h00);
            run_frame();
        end

        // reset after the 6th data byte of a 3-word frame
        max_gap = 1;
        w_q = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
        build_frame(8'h00);
        obs_wr_q.delete();
        for (int b = 0; b < 9; b++) send_byte(frame_q[b], b);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        check("writes_before_rst", 32'(obs_wr_q.size()), 32'd1);
        if (obs_wr_q.size() > 0)
            check("rst_frame_addr", obs_wr_q[0][63:32], 32'h8000_0000);
        $display("reset mid-frame writes=%0d", obs_wr_q.size());
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        w_q = '{32'h0000_0013, 32'h0050_0093, 32'h0010_8113};
        build_frame(8'h00);
        run_frame();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. Receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Issues one write per word into the instruction memory write port, at byte addresses starting from the instruction base 0x8000_0000.
- Holds the core (cpu_hold) while a program is being loaded.
- Sits between the boot byte source (UART RX FIFO or testbench) and the instruction memory.

Parameters:
- width, 32, data/address width of the memory write port
- depth, 255, instruction memory depth in words; the largest legal word count
- BASE_ADDR, 32'h8000_0000, byte address of word 0 (word index = addr[31:2] - 32'h2000_0000)
- SYNC_BYTE, 8'hA5, frame start marker

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts a byte this cycle; transfer happens when rx_valid && rx_ready
- wr_en  out  1  one-cycle instruction memory write strobe
- wr_addr  out  width  byte address of the write
- wr_data  out  width  instruction word to write
- cpu_hold  out  1  core held (stalled/reset) while loading
- load_done  out  1  one-cycle pulse: frame loaded and checksum correct
- load_err  out  1  sticky error flag; cleared by the next SYNC_BYTE
- words_loaded  out  8  count of words written in the current frame

Behaviour:
- Reset (async, active-high) sets: state IDLE, rx_ready=1, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=0, load_done=0, load_err=0, words_loaded=0, checksum=0, byte index=0.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then 4*N data bytes (little-endian per word, LSB first), then CSUM. N = {LEN_HI,LEN_LO}. CSUM = XOR of all 4*N data bytes.
- FSM states:
  - IDLE: discards non-sync bytes. On SYNC_BYTE goes to LEN_LO, clears load_err, words_loaded, checksum; sets cpu_hold=1.
  - LEN_LO: latches the low byte, goes to LEN_HI.
  - LEN_HI: latches the high byte. If N==0 or N>depth: go to ERR. Else go to DATA.
  - DATA: shifts each byte into bits [8k+7:8k] for k = 0..3 and XORs it into the checksum. On the 4th byte, wr_en=1 in the next cycle with wr_data = the assembled word and wr_addr = BASE_ADDR + 4*words_loaded. words_loaded increments in that same write cycle. After word N is accepted, go to CSUM.
  - CSUM: on a match, load_done pulses for one cycle, cpu_hold drops in the same cycle, go to IDLE. On a mismatch, go to ERR.
  - ERR: load_err=1 and cpu_hold=0 for one cycle, then IDLE. load_err stays 1 until the next SYNC_BYTE.
- rx_ready is 1 in IDLE, LEN_LO, LEN_HI, DATA and CSUM. It is 0 in ERR and in the write cycle (wr_en=1). This gives at most one word in flight and no write/accept collision.
- Latency: 4th byte accepted at cycle t, wr_en high at t+1. Back-to-back bytes give one write per 5 cycles minimum.
- Bytes with rx_valid=0 are ignored. Gaps of any length are allowed in every state.
- A SYNC_BYTE value inside DATA/LEN/CSUM is treated as data; there is no resync mid-frame.
- words_loaded never exceeds depth. wr_addr arithmetic is 32-bit and never wraps within a legal frame.
- Reset mid-frame: immediate return to IDLE, cpu_hold=0. Words already written stay in memory. The next frame starts clean.
- The checksum error is reported after the data writes have occurred. Memory content is undefined on load_err and the core must not be released to run it (the system controller checks load_err).

Decomposition:
- Shared package imem_pkg holds:
  - loader_state_t enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, ERR)
  - IMEM_BASE_ADDR = 32'h8000_0000
  - IMEM_WORD_OFFSET = 32'h2000_0000
  - IMEM_DEPTH = 255
  - LOADER_SYNC = 8'hA5
- Instruction memory uses the same constants.
- One natural sub-module, byte_to_word_asm: shift register, byte index counter and word_valid strobe. The FSM, checksum and address counter stay in imem_loader.

Test Plan:
- Reset, then send A5 01 00 13 00 00 00 13 (one NOP, CSUM = 0x13) back-to-back:
  - single wr_en with wr_addr=0x8000_0000, wr_data=0x0000_0013, one cycle after the 4th data byte
  - load_done pulses once, cpu_hold high from the cycle after A5 until load_done, words_loaded=1
- Two words 0x0050_0093 and 0x0010_8113, with rx_valid gaps of 0..3 random cycles:
  - writes at 0x8000_0000 then 0x8000_0004 with the exact words
  - rx_ready low during each wr_en cycle
  - CSUM = XOR of the 8 bytes gives load_done
- Length 0 (A5 00 00) and length 256 (A5 00 01): ERR, load_err=1, no wr_en, cpu_hold=0. A following valid frame clears load_err at its A5.
- Correct frame with CSUM off by 0x01: all N writes occur, then load_err=1, no load_done.
- Garbage 00 FF 13 before A5: ignored in IDLE, no state change. 0xA5 as a data byte is stored as data.
- Assert rst after the 6th data byte of a 3-word frame:
  - all outputs return to reset values asynchronously, with exactly one write having occurred
  - a new full frame then loads correctly from 0x8000_0000
